// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem request at a time,
// hands fetched instructions to decode and squashes fetches made stale by redirects.
module fetch_sequencer #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
    parameter int               INSTR_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc
);
    localparam logic [WIDTH-1:0] STEP  = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN = ~(STEP - WIDTH'(1));

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pc, pc_n;
    logic [WIDTH-1:0] fetch_addr, fetch_addr_n;
    logic [WIDTH-1:0] instr_n, opc_n;
    logic [WIDTH-1:0] tgt;

    assign tgt = redirect_addr & ALIGN;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_ADDR;
            fetch_addr <= RESET_ADDR;
            out_instr  <= '0;
            out_pc     <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            fetch_addr <= fetch_addr_n;
            out_instr  <= instr_n;
            out_pc     <= opc_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        fetch_addr_n = fetch_addr;
        instr_n      = out_instr;
        opc_n        = out_pc;
        case (state)
            IDLE: begin
                state_n = FETCH;
                if (redirect) begin
                    pc_n         = tgt;
                    fetch_addr_n = tgt;
                end else begin
                    fetch_addr_n = pc;
                end
            end
            FETCH: begin
                if (imem_ack && redirect) begin
                    // returned word belongs to the old path; re-request at the target
                    pc_n         = tgt;
                    fetch_addr_n = tgt;
                end else if (imem_ack) begin
                    instr_n = imem_rdata;
                    opc_n   = fetch_addr;
                    pc_n    = fetch_addr + STEP;
                    state_n = OUT;
                end else if (redirect) begin
                    // request cannot be withdrawn; wait out the stale ack in DRAIN
                    pc_n    = tgt;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect) pc_n = tgt;
                if (imem_ack) begin
                    fetch_addr_n = redirect ? tgt : pc;
                    state_n      = FETCH;
                end
            end
            OUT: begin
                if (redirect) begin
                    pc_n         = tgt;
                    fetch_addr_n = tgt;
                    state_n      = FETCH;
                end else if (out_ready) begin
                    fetch_addr_n = pc;
                    state_n      = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = fetch_addr;
    assign out_valid = (state == OUT);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences every instruction-memory access in the core. It issues one fetch at a time to instruction memory over a req/ack handshake and presents each fetched instruction with its address to the decode stage over a valid/ready handshake. It applies jump/branch redirects from execute and squashes any fetch made stale by a redirect.

## Interface
- WIDTH, 32: address and instruction width in bits.
- RESET_ADDR, 0: PC value after reset.
- INSTR_BYTES, 4: PC increment per sequential fetch; power of two.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; once asserted, held until imem_ack.
- imem_addr  out  WIDTH  fetch address; stable while imem_req is high.
- imem_ack  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  WIDTH  instruction word.
- redirect  in  1  one-cycle jump/branch request from execute.
- redirect_addr  in  WIDTH  redirect target; the low log2(INSTR_BYTES) bits are forced to 0.
- out_valid  out  1  out_instr and out_pc are valid.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  WIDTH  fetched instruction.
- out_pc  out  WIDTH  address out_instr was fetched from.

## Operation
- State registers: `state`, `pc` (next address to fetch), `fetch_addr` (address of the outstanding request), `out_instr`, `out_pc`.
- States: IDLE, FETCH, DRAIN, OUT.
- IDLE
  - imem_req=0, out_valid=0.
  - Next state is always FETCH; fetch_addr<=pc.
  - A redirect in IDLE sets pc<=redirect_addr and fetch_addr<=redirect_addr.
- FETCH
  - imem_req=1, imem_addr=fetch_addr.
  - imem_ack & !redirect: out_instr<=imem_rdata, out_pc<=fetch_addr, pc<=fetch_addr+INSTR_BYTES, go to OUT.
  - imem_ack & redirect: discard rdata, pc<=fetch_addr<=redirect_addr, stay in FETCH (new request next cycle).
  - !imem_ack & redirect: pc<=redirect_addr, go to DRAIN; fetch_addr is unchanged, so the request is not withdrawn.
  - No ack, no redirect: hold.
- DRAIN
  - imem_req=1, imem_addr=fetch_addr (the stale address).
  - On imem_ack: discard rdata, fetch_addr<=pc, go to FETCH.
  - A redirect in DRAIN overwrites pc; the latest redirect wins.
  - If redirect and imem_ack coincide, fetch_addr<=redirect_addr.
- OUT
  - out_valid=1, imem_req=0.
  - A transfer occurs iff out_valid & out_ready, regardless of redirect.
  - Transfer without redirect: fetch_addr<=pc, go to FETCH.
  - Redirect (with or without transfer): pc<=fetch_addr<=redirect_addr, go to FETCH. Without a transfer, the held instruction is squashed and out_valid drops next cycle.
  - No transfer, no redirect: hold all outputs stable.
- Arithmetic: the PC increments modulo 2^WIDTH; 2^WIDTH-INSTR_BYTES wraps to 0.
- imem_ack is ignored in IDLE and OUT.
- Only one fetch is ever outstanding.

## Timing
- Reset values
  - state=IDLE, pc=RESET_ADDR, fetch_addr=RESET_ADDR.
  - imem_req=0, imem_addr=RESET_ADDR, out_valid=0, out_instr=0, out_pc=0.
- After rst falls, imem_req rises on the 2nd edge (IDLE, then FETCH).
- Outputs decode from registers only; there is no combinational path from any input to any output.
- Latencies
  - ack at cycle N -> out_valid at N+1.
  - Transfer at N -> imem_req at N+1.
  - Redirect at N (FETCH with ack, or OUT) -> imem_req with redirect_addr at N+1.
  - Redirect at N with no ack -> new request one cycle after the stale ack.
- Throughput: back-to-back zero-wait memory with out_ready=1 yields one instruction per 2 cycles.
- rst mid-operation: an outstanding request is abandoned at once (imem_req=0 next cycle); instruction memory is reset by the same rst.

## Test plan
- Reset release, ack in the same cycle as every req, out_ready=1: requests go to 0x0, 0x4, 0x8; out_pc=0,4,8 with matching out_instr; imem_req is first high on the 2nd cycle after reset.
- 3-cycle ack latency, then out_ready held low 4 cycles: imem_addr stays 0x0 until ack; out_valid and out_instr stay stable; no new req until the transfer.
- Redirect to 0x100 on cycle 1 of a 3-cycle fetch at 0x8 -> DRAIN; stale rdata is never presented; the next req is at 0x100; out_pc=0x100, then 0x104.
- Redirect to 0x40 while in OUT with out_ready=0 -> instruction squashed, out_valid=0 next cycle, next req at 0x40. Repeat with out_ready=1 in the same cycle: the instruction transfers and the next req is still at 0x40.
- RESET_ADDR=0xFFFFFFFC, WIDTH=32: the second fetch is at 0x0. redirect_addr=0x103 fetches 0x100.
- rst asserted while DRAIN is waiting for ack: imem_req=0 and out_valid=0 next cycle; restart at RESET_ADDR.
